// File: rtl/alu_seq_ctrl_if.sv
// Command channel between a requester and alu_seq_ctrl: one ALU operation
// per valid/ready handshake, with source/destination register addresses.
interface alu_seq_ctrl_if #(
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;
  logic          cmd_wb;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    output cmd_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for an external combinational ALU: fetches operands from a small
// register file, captures result/flags, and optionally writes the result back.
module alu_seq_ctrl #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave cmd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_op,
  input  logic [N-1:0]  alu_y,
  input  logic          alu_c,
  input  logic          alu_zero,
  output logic          done,
  output logic [N-1:0]  res,
  output logic          c_flag,
  output logic          z_flag
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t        state_r;
  logic [N-1:0]  rf_r [DEPTH];
  logic [2:0]    op_r;
  logic [AW-1:0] ra_r;
  logic [AW-1:0] rb_r;
  logic [AW-1:0] rd_r;
  logic          wb_r;

  // Host read port is a plain combinational view of the register file.
  assign rd_data = rf_r[rd_addr];

  // Controller FSM, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cmd.cmd_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= '0;
      end
      op_r   <= 3'd0;
      ra_r   <= '0;
      rb_r   <= '0;
      rd_r   <= '0;
      wb_r   <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 3'd0;
      res    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          // A load in the accept cycle commits now, so FETCH sees it.
          if (ld_en) begin
            rf_r[ld_addr] <= ld_data;
          end else begin
            rf_r[ld_addr] <= rf_r[ld_addr];
          end
          if (cmd.cmd_valid) begin
            op_r          <= cmd.cmd_op;
            ra_r          <= cmd.cmd_ra;
            rb_r          <= cmd.cmd_rb;
            rd_r          <= cmd.cmd_rd;
            wb_r          <= cmd.cmd_wb;
            cmd.cmd_ready <= 1'b0;
            state_r       <= FETCH;
          end else begin
            cmd.cmd_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        FETCH: begin
          alu_a   <= rf_r[ra_r];
          alu_b   <= rf_r[rb_r];
          alu_op  <= op_r;
          state_r <= EXEC;
        end
        EXEC: begin
          res     <= alu_y;
          c_flag  <= alu_c;
          z_flag  <= alu_zero;
          done    <= 1'b1;
          state_r <= WB;
        end
        WB: begin
          if (wb_r) begin
            rf_r[rd_r] <= res;
          end else begin
            rf_r[rd_r] <= rf_r[rd_r];
          end
          done          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          done          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 8-opcode ALU attached
// to the alu_* ports; expected values are hand-computed per step.
module tb_alu_seq_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd6;

  logic          clk;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_data;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_y;
  logic          alu_c;
  logic          alu_zero;
  logic          done;
  logic [N-1:0]  res;
  logic          c_flag;
  logic          z_flag;

  int vectors;
  int miscompares;

  alu_seq_ctrl_if #(.AW(AW)) cmd_bus ();

  alu_seq_ctrl #(.N(N), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_c    (alu_c),
    .alu_zero (alu_zero),
    .done     (done),
    .res      (res),
    .c_flag   (c_flag),
    .z_flag   (z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: carry is bit N of the 9-bit result, zero means {c,Y}==0.
  always_comb begin
    logic [N:0] t;
    t = '0;
    case (alu_op)
      3'd0:    t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    t = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2:    t = {1'b0, alu_a & alu_b};
      3'd3:    t = {1'b0, alu_a | alu_b};
      3'd4:    t = {1'b0, ~alu_a};
      3'd5:    t = {1'b0, alu_a ^ alu_b};
      3'd6:    t = {1'b0, alu_a << alu_b[2:0]};
      default: t = {1'b0, alu_a >> alu_b[2:0]};
    endcase
    alu_y    = t[N-1:0];
    alu_c    = t[N];
    alu_zero = (t == '0);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic [AW-1:0] a, input logic [N-1:0] exp);
    rd_addr = a;
    #1;
    chk(tag, {8'h00, rd_data}, {8'h00, exp});
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                         input logic wb);
    cmd_bus.cmd_op = op;
    cmd_bus.cmd_ra = ra;
    cmd_bus.cmd_rb = rb;
    cmd_bus.cmd_rd = rd;
    cmd_bus.cmd_wb = wb;
  endtask

  // Wait (bounded) for ready, then offer the command across one accept edge.
  task automatic accept(input string tag);
    int n;
    n = 0;
    while (cmd_bus.cmd_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_ready_wait"}, {15'd0, cmd_bus.cmd_ready}, 16'd1);
    cmd_bus.cmd_valid = 1'b1;
    step();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Runs FETCH/EXEC/WB after an accept and checks result and flags at WB.
  task automatic finish_op(input string tag, input logic [N-1:0] e_res,
                           input logic e_c, input logic e_z);
    step();
    chk({tag, "_done_early"}, {15'd0, done}, 16'd0);
    step();
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_res"}, {8'h00, res}, {8'h00, e_res});
    chk({tag, "_cz"}, {14'd0, c_flag, z_flag}, {14'd0, e_c, e_z});
    step();
    chk({tag, "_done_end"}, {15'd0, done}, 16'd0);
    chk({tag, "_ready_back"}, {15'd0, cmd_bus.cmd_ready}, 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    rd_addr = '0;
    cmd_bus.cmd_valid = 1'b0;
    set_cmd(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    chk("rst_ready", {15'd0, cmd_bus.cmd_ready}, 16'd1);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_res", {8'h00, res}, 16'h0000);
    chk("rst_alu", {alu_a, alu_b}, 16'h0000);
    chk("rst_op_cz", {11'd0, alu_op, c_flag, z_flag}, 16'd0);

    // ADD with write-back
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1);
    accept("add");
    chk("add_ready_low", {15'd0, cmd_bus.cmd_ready}, 16'd0);
    finish_op("add", 8'h08, 1'b0, 1'b0);
    chk_rf("add_wb_r3", 3'd3, 8'h08);

    // ADD producing carry, no write-back
    load(3'd1, 8'hFF);
    load(3'd2, 8'h01);
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 1'b0);
    accept("addc");
    finish_op("addc", 8'h00, 1'b1, 1'b0);
    chk_rf("addc_r0", 3'd0, 8'h00);

    // SUB with ra==rb, rd left alone
    load(3'd4, 8'h05);
    load(3'd5, 8'h77);
    set_cmd(OP_SUB, 3'd4, 3'd4, 3'd5, 1'b0);
    accept("sub");
    finish_op("sub", 8'h00, 1'b0, 1'b1);
    chk_rf("sub_r5", 3'd5, 8'h77);

    // Back-to-back dependent ops with valid held high
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    load(3'd7, 8'h01);
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1);
    cmd_bus.cmd_valid = 1'b1;
    step();                                   // T0: first accept
    set_cmd(OP_SLL, 3'd3, 3'd7, 3'd6, 1'b1);
    chk("b2b_ready_t0", {15'd0, cmd_bus.cmd_ready}, 16'd0);
    step();                                   // T1
    chk("b2b_alu_t1", {alu_a, alu_b}, 16'h0503);
    step();                                   // T2
    chk("b2b_res1", {7'd0, done, res}, 16'h0108);
    step();                                   // T3
    chk("b2b_ready_t3", {15'd0, cmd_bus.cmd_ready}, 16'd1);
    step();                                   // T4: second accept
    cmd_bus.cmd_valid = 1'b0;
    chk("b2b_ready_t4", {15'd0, cmd_bus.cmd_ready}, 16'd0);
    step();                                   // T5
    chk("b2b_alu_t5", {5'd0, alu_op, alu_a}, {5'd0, OP_SLL, 8'h08});
    step();                                   // T6
    chk("b2b_res2", {7'd0, done, res}, 16'h0110);
    step();                                   // T7
    chk_rf("b2b_r6", 3'd6, 8'h10);

    // Host load during EXEC is ignored
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 1'b0);
    accept("ldx");
    step();                                   // now in EXEC
    ld_en = 1'b1;
    ld_addr = 3'd1;
    ld_data = 8'hAA;
    step();
    ld_en = 1'b0;
    chk("ldx_res", {8'h00, res}, 16'h0008);
    step();
    chk_rf("ldx_r1", 3'd1, 8'h05);

    // Load and accept in the same IDLE cycle
    ld_en = 1'b1;
    ld_addr = 3'd1;
    ld_data = 8'h0A;
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd4, 1'b1);
    accept("ldacc");
    ld_en = 1'b0;
    finish_op("ldacc", 8'h0D, 1'b0, 1'b0);
    chk_rf("ldacc_r4", 3'd4, 8'h0D);

    // Reset asserted during EXEC aborts the operation
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1);
    accept("rstx");
    step();                                   // in EXEC
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstx_ready", {15'd0, cmd_bus.cmd_ready}, 16'd1);
    chk("rstx_res_done", {7'd0, done, res}, 16'h0000);
    chk("rstx_alu", {alu_a, alu_b}, 16'h0000);
    chk_rf("rstx_r1", 3'd1, 8'h00);
    step();
    chk("rstx_no_done", {15'd0, done}, 16'd0);
    rst_n = 1'b1;
    step();
    chk("rstx_no_done2", {15'd0, done}, 16'd0);
    chk_rf("rstx_r3", 3'd3, 8'h00);

    // Normal operation resumes after reset
    load(3'd1, 8'h02);
    load(3'd2, 8'h03);
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1);
    accept("resume");
    finish_op("resume", 8'h05, 1'b0, 1'b0);
    chk_rf("resume_r3", 3'd3, 8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the N-bit, 8-opcode ALU (ADD, SUB, AND, OR, NOT, XOR, SLL, SRL; carry-out and zero outputs). It holds a small internal register file, accepts one operation command at a time through a valid/ready handshake, and fetches both operands from the register file into registered ALU inputs. It then captures the ALU result and flags and optionally writes the result back. It sits between the host/test logic and the combinational ALU, which is instantiated alongside it and wired to the `alu_*` ports.

## Interface
- `N`, 8, datapath width; must match the ALU's N
- `AW`, 3, register-file address width; 2^AW words of N bits
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept; equals (state == IDLE)
- `cmd_op`  in  3  ALU opcode, passed unmodified
- `cmd_ra`, `cmd_rb`  in  AW each  source register addresses for A and B
- `cmd_rd`  in  AW  destination register address
- `cmd_wb`  in  1  1 = write the result to `rd`; 0 = flags/result only
- `ld_en`  in  1  host register-file write strobe
- `ld_addr`  in  AW  host write address
- `ld_data`  in  N  host write data
- `rd_addr`  in  AW  host read address
- `rd_data`  out  N  combinational read of rf[`rd_addr`]
- `alu_a`, `alu_b`  out  N each  registered ALU operands
- `alu_op`  out  3  registered ALU opcode
- `alu_y`  in  N  ALU result
- `alu_c`  in  1  ALU carry/borrow
- `alu_zero`  in  1  ALU zero flag
- `done`  out  1  one-cycle pulse marking operation complete
- `res`  out  N  last captured result
- `c_flag`, `z_flag`  out  1 each  last captured carry and zero

## Operation
- FSM states: IDLE → FETCH → EXEC → WB → IDLE. No other transitions exist except reset.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch op, ra, rb, rd and wb, then go to FETCH.
- **FETCH:** register `alu_a`←rf[ra], `alu_b`←rf[rb], `alu_op`←op, then go to EXEC.
- **EXEC:** the ALU settles combinationally. At the end of the cycle, capture `res`←`alu_y`, `c_flag`←`alu_c`, `z_flag`←`alu_zero`, then go to WB.
- **WB:** `done`=1 for this cycle only. At the end of the cycle, if wb=1 then rf[rd]←`res`. Go to IDLE.
- Host load is honoured only in IDLE. `ld_en` in any other state is ignored and rf is unchanged.
- If `ld_en` and a command accept occur in the same IDLE cycle, the load commits at that edge. FETCH therefore sees the loaded value.
- ra==rb is legal; both operands read the same word.
- If rd equals a source register, the new value is visible to the next command and to `rd_data` after the WB edge.
- `cmd_valid` asserted outside IDLE is not accepted. The command fields must be held by the requester until accepted.
- `alu_a`, `alu_b`, `alu_op`, `res`, `c_flag` and `z_flag` hold their values between operations.
- No arithmetic is done in this block. Width, carry and zero semantics are entirely the ALU's (zero means {c,Y}==0).

## Timing
- **Reset values (async, `rst_n`=0):** state IDLE, all rf words 0, `alu_a`/`alu_b`/`alu_op`=0, `res`=0, `c_flag`=0, `z_flag`=0, `done`=0, `cmd_ready`=1.
- **Latency:** with accept at edge T0, `alu_*` update at T1, flags/`res` update at T2, and `done` is high during T2–T3. The rf write commits at T3, and `cmd_ready` returns to 1 after T3.
- **Throughput:** one command per 4 cycles. With `cmd_valid` held high, successive accepts are exactly 4 edges apart.
- **Reset mid-operation:** the operation aborts immediately, there is no write-back, and no `done` is produced. Normal operation resumes in IDLE on the first edge after `rst_n` rises.

## Test plan
- **ADD, write-back:** load r1=0x05, r2=0x03; issue ADD ra=1 rb=2 rd=3 wb=1. Expect `done` 2 edges after accept, `res`=0x08, c=0, z=0, and rd_data(3)=0x08 after WB.
- **ADD with carry:** r1=0xFF, r2=0x01, ADD. Expect `res`=0x00, c=1, z=0.
- **SUB, no write-back:** r4=0x05, SUB ra=4 rb=4 rd=5 wb=0. Expect `res`=0x00, c=0, z=1, and rf[5] unchanged.
- **Back-to-back dependent ops:** with `cmd_valid` held, issue ADD r3←r1+r2, then SLL r6←r3<<r7 with r7=0x01. Expect the second accept 4 edges after the first and `res`=0x10.
- **Load interactions:** `ld_en` during EXEC → rf unchanged. `ld_en` r1=0x0A in the same cycle as accepting ADD r1+r2 (r2=0x03) → `res`=0x0D.
- **Reset in EXEC:** drop `rst_n` during EXEC. Expect all outputs at reset values at once, all rf words 0, no `done` pulse, and `cmd_ready`=1.
